alu_issue_scheduler: RTL and testbench
======================================

Name: alu_issue_scheduler

Overview:
- Sits between the ALU reservation-station entries and the ALU issue/execute stage.
- Each cycle it selects the oldest ready entry, using ROB-tag age relative to the ROB head, and grants that entry.
- The selected operands, commands and tag go into a single holding register that drives the ALU stage.
- The holding register uses a valid/canGo handshake, supports flush, and keeps a saturating issue counter.

Parameters:
- ROBsize, 32, number of ROB entries; tags range 0..ROBsize-1.
- ROBsizeLog, $clog2(ROBsize+1), width of tag and head fields.
- NUM_RS, 4, number of reservation-station entries competing for the ALU.
- CNT_W, 16, width of the issue performance counter.

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_i  in  NUM_RS  entry i is ready to issue.
- reqTag_i  in  NUM_RS*ROBsizeLog  packed ROB tags; entry i at [i*ROBsizeLog +: ROBsizeLog].
- reqVal1_i  in  NUM_RS*64  packed operand A per entry.
- reqVal2_i  in  NUM_RS*64  packed operand B per entry.
- reqCommands_i  in  NUM_RS*10  packed 10-bit command per entry; bits [4:2] are the ALU op.
- robHead_i  in  ROBsizeLog  current ROB head (oldest) tag.
- canGo_i  in  1  downstream accepts the held op this cycle.
- flush_i  in  1  squash the held op and suppress grant this cycle.
- grant_o  out  NUM_RS  one-hot; entry i is dequeued at this edge.
- aluVal1_o  out  64  held operand A.
- aluVal2_o  out  64  held operand B.
- aluCommands_o  out  10  held command.
- aluTag_o  out  ROBsizeLog  held ROB tag.
- aluValid_o  out  1  holding register contains a live op.
- stall_o  out  1  aluValid_o & ~canGo_i; a requester must hold.
- issueCount_o  out  CNT_W  saturating count of grants since reset.

Behaviour:
- Reset (reset_i=0, async): aluValid_o=0; aluVal1_o, aluVal2_o, aluCommands_o, aluTag_o and issueCount_o all 0; grant_o=0 combinationally while in reset.
- State machine on aluValid_o:
  - EMPTY (valid=0).
  - FULL (valid=1).
- Load enable: load = ~flush_i & (~aluValid_o | canGo_i).
- Selection is combinational.
  - age(i) = (reqTag_i[i] >= robHead_i) ? reqTag_i[i]-robHead_i : reqTag_i[i]+ROBsize-robHead_i.
  - Width is ROBsizeLog; wrap-around is handled by this formula.
  - Winner = the requesting entry with minimum age.
  - Equal ages cannot occur legally; if they do, the lowest index wins.
- Grant: grant_o[winner]=1 iff load & |req_i; otherwise all grant_o bits are 0.
- Transitions at the rising edge:
  - EMPTY, load & |req_i -> FULL, capturing the winner's val1, val2, commands and tag.
  - EMPTY, otherwise -> stay EMPTY; data regs hold.
  - FULL, canGo_i & |req_i & ~flush_i -> FULL with the new winner (back-to-back, one issue per cycle).
  - FULL, canGo_i & ~|req_i -> EMPTY.
  - FULL, ~canGo_i & ~flush_i -> FULL; all data held, grant_o=0.
  - Any state, flush_i -> EMPTY; grant_o=0; flush takes priority over canGo_i and req_i.
- Latency: a request granted at edge N appears on the alu*_o outputs after edge N.
- Throughput: 1 op/cycle.
- issueCount_o increments on every edge where |grant_o, and saturates at 2^CNT_W-1.
- Data registers are don't-care when aluValid_o=0, but must only change on load.
- Reset asserted mid-operation immediately clears valid and the counter; there is no partial grant.

Decomposition:
- Package alu_sched_pkg holds:
  - localparams ALU_CMD_W=10 and DATA_W=64.
  - typedef alu_issue_t, a struct of val1, val2, commands, tag.
  - function robAge(tag, head).
- One sub-module, oldest_ready_select:
  - Combinational min-age tree over NUM_RS entries.
  - Outputs winner index, one-hot, and anyValid.

Test Plan:
- Reset, then head=0 with req_i=4'b0110, tags {e1=5, e2=3} and canGo_i=1 -> grant_o=4'b0100; next cycle aluTag_o=3, aluValid_o=1, issueCount_o=1.
- Wrap: head=30, ROBsize=32, tags e0=1 and e3=31, both requesting -> e3 granted (age 1 < age 3); aluTag_o=31.
- Backpressure: FULL with canGo_i=0 for 3 cycles while req_i=4'b0001 -> grant_o=0, stall_o=1 and outputs held; canGo_i=1 -> grant_o=4'b0001 the same cycle.
- Flush: FULL with flush_i=1, canGo_i=1, req_i=4'b1111 -> grant_o=0; next cycle aluValid_o=0 and issueCount_o unchanged.
- Streaming: 4 entries ready, canGo_i=1 and each req dropped after its grant -> 4 grants on consecutive cycles in age order; then EMPTY.
- Async reset mid-stream: drop reset_i between edges -> aluValid_o=0 and issueCount_o=0 immediately without a clock edge; CNT_W=4 variant saturates at 15 after 20 grants.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types, widths and the ROB age helper for the ALU issue scheduler.
package alu_sched_pkg;

  localparam int unsigned ALU_CMD_W = 10;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ROB_SIZE  = 32;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_SIZE + 1);

  // Holding register state: EMPTY / FULL.
  typedef enum logic {StEmpty, StFull} sched_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]    val1;
    logic [DATA_W-1:0]    val2;
    logic [ALU_CMD_W-1:0] commands;
    logic [ROB_TAG_W-1:0] tag;
  } alu_issue_t;

  // Distance of a tag from the ROB head, wrapping at rob_size.
  function automatic int unsigned robAge(input int unsigned tag, input int unsigned head,
                                         input int unsigned rob_size);
    if (tag >= head) begin
      return tag - head;
    end
    return tag + rob_size - head;
  endfunction

endpackage

// File: rtl/oldest_ready_select.sv
// Combinational oldest-ready picker: minimum ROB age among requesters, lowest index on ties.
module oldest_ready_select
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_RS     = 4,
  parameter int unsigned ROBsize    = 32,
  parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
  parameter int unsigned IdxW       = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic [NUM_RS-1:0]            i_req,
  input  logic [NUM_RS*ROBsizeLog-1:0] i_tag,
  input  logic [ROBsizeLog-1:0]        i_head,
  output logic [IdxW-1:0]              o_winner,
  output logic [NUM_RS-1:0]            o_onehot,
  output logic                         o_any_valid
);

  logic [ROBsizeLog-1:0] w_age;
  logic [ROBsizeLog-1:0] w_best_age;
  logic                  w_found;

  // Scan entries; strict less-than keeps the lowest index on equal ages.
  always_comb begin
    w_age      = '0;
    w_best_age = '0;
    w_found    = 1'b0;
    o_winner   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_age = ROBsizeLog'(robAge(32'(i_tag[i*ROBsizeLog +: ROBsizeLog]), 32'(i_head), ROBsize));
      if (i_req[i] && (!w_found || (w_age < w_best_age))) begin
        w_found    = 1'b1;
        w_best_age = w_age;
        o_winner   = IdxW'(i);
      end
    end
    o_onehot           = '0;
    o_onehot[o_winner] = w_found;
    o_any_valid        = w_found;
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Grants the oldest ready RS entry and holds its op in a valid/canGo register for the ALU.
module alu_issue_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned ROBsize    = 32,
  parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
  parameter int unsigned NUM_RS     = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_RS-1:0]              req_i,
  input  logic [NUM_RS*ROBsizeLog-1:0]   reqTag_i,
  input  logic [NUM_RS*DATA_W-1:0]       reqVal1_i,
  input  logic [NUM_RS*DATA_W-1:0]       reqVal2_i,
  input  logic [NUM_RS*ALU_CMD_W-1:0]    reqCommands_i,
  input  logic [ROBsizeLog-1:0]          robHead_i,
  input  logic                           canGo_i,
  input  logic                           flush_i,
  output logic [NUM_RS-1:0]              grant_o,
  output logic [DATA_W-1:0]              aluVal1_o,
  output logic [DATA_W-1:0]              aluVal2_o,
  output logic [ALU_CMD_W-1:0]           aluCommands_o,
  output logic [ROBsizeLog-1:0]          aluTag_o,
  output logic                           aluValid_o,
  output logic                           stall_o,
  output logic [CNT_W-1:0]               issueCount_o
);

  localparam int unsigned IdxW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [IdxW-1:0]   w_winner;
  logic [NUM_RS-1:0] w_onehot;
  logic              w_any;
  logic              w_load;
  alu_issue_t        w_sel;

  sched_state_e      r_state;
  alu_issue_t        r_issue;
  logic [CNT_W-1:0]  r_count;

  oldest_ready_select #(
    .NUM_RS    (NUM_RS),
    .ROBsize   (ROBsize),
    .ROBsizeLog(ROBsizeLog),
    .IdxW      (IdxW)
  ) u_select (
    .i_req      (req_i),
    .i_tag      (reqTag_i),
    .i_head     (robHead_i),
    .o_winner   (w_winner),
    .o_onehot   (w_onehot),
    .o_any_valid(w_any)
  );

  // Mux the winning entry's payload into the holding-register format.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (w_winner == IdxW'(i)) begin
        w_sel.val1     = reqVal1_i[i*DATA_W +: DATA_W];
        w_sel.val2     = reqVal2_i[i*DATA_W +: DATA_W];
        w_sel.commands = reqCommands_i[i*ALU_CMD_W +: ALU_CMD_W];
        w_sel.tag      = ROB_TAG_W'(reqTag_i[i*ROBsizeLog +: ROBsizeLog]);
      end
    end
  end

  // Load when not flushing and the holding register is free or draining this cycle.
  always_comb begin
    w_load  = ~flush_i & (~aluValid_o | canGo_i);
    grant_o = (reset_i && w_load && w_any) ? w_onehot : '0;
  end

  // Holding-register FSM; flush wins over canGo and requests.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= StEmpty;
      r_issue <= '0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (!flush_i && w_any) begin
            r_state <= StFull;
            r_issue <= w_sel;
          end
        end
        StFull: begin
          if (flush_i) begin
            r_state <= StEmpty;
          end else if (canGo_i) begin
            if (w_any) begin
              r_issue <= w_sel;
            end else begin
              r_state <= StEmpty;
            end
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  // Saturating count of grants.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else if (|grant_o && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Outputs come straight from registers; stall is the backpressure view.
  always_comb begin
    aluValid_o    = (r_state == StFull);
    aluVal1_o     = r_issue.val1;
    aluVal2_o     = r_issue.val2;
    aluCommands_o = r_issue.commands;
    aluTag_o      = ROBsizeLog'(r_issue.tag);
    stall_o       = aluValid_o & ~canGo_i;
    issueCount_o  = r_count;
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Randomised and directed checks of alu_issue_scheduler against a queue-free behavioural model.
module tb_alu_issue_scheduler;

  localparam int RS = 32;
  localparam int TW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  req;
  logic [TW-1:0] tags [4];
  logic [63:0] v1 [4];
  logic [63:0] v2 [4];
  logic [9:0]  cmd [4];
  logic [TW-1:0] head;
  logic        can_go;
  logic        flush;

  logic [4*TW-1:0] tag_p;
  logic [255:0]    v1_p;
  logic [255:0]    v2_p;
  logic [39:0]     cmd_p;

  always_comb begin
    tag_p = '0;
    v1_p  = '0;
    v2_p  = '0;
    cmd_p = '0;
    for (int i = 0; i < 4; i++) begin
      tag_p[i*TW +: TW] = tags[i];
      v1_p[i*64 +: 64]  = v1[i];
      v2_p[i*64 +: 64]  = v2[i];
      cmd_p[i*10 +: 10] = cmd[i];
    end
  end

  logic [3:0]    grant, d4_grant;
  logic [63:0]   a1, a2, d4_a1, d4_a2;
  logic [9:0]    acmd, d4_acmd;
  logic [TW-1:0] atag, d4_atag;
  logic          avalid, stall, d4_avalid, d4_stall;
  logic [15:0]   cnt16;
  logic [3:0]    cnt4;

  alu_issue_scheduler #(.ROBsize(32), .NUM_RS(4), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .reqTag_i(tag_p), .reqVal1_i(v1_p),
    .reqVal2_i(v2_p), .reqCommands_i(cmd_p), .robHead_i(head), .canGo_i(can_go),
    .flush_i(flush), .grant_o(grant), .aluVal1_o(a1), .aluVal2_o(a2), .aluCommands_o(acmd),
    .aluTag_o(atag), .aluValid_o(avalid), .stall_o(stall), .issueCount_o(cnt16)
  );

  alu_issue_scheduler #(.ROBsize(32), .NUM_RS(4), .CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .reqTag_i(tag_p), .reqVal1_i(v1_p),
    .reqVal2_i(v2_p), .reqCommands_i(cmd_p), .robHead_i(head), .canGo_i(can_go),
    .flush_i(flush), .grant_o(d4_grant), .aluVal1_o(d4_a1), .aluVal2_o(d4_a2),
    .aluCommands_o(d4_acmd), .aluTag_o(d4_atag), .aluValid_o(d4_avalid), .stall_o(d4_stall),
    .issueCount_o(cnt4)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_valid;
  logic [63:0] m_v1, m_v2;
  logic [9:0]  m_cmd;
  logic [TW-1:0] m_tag;
  int          m_cnt16, m_cnt4;

  function automatic int ref_winner();
    int best = -1;
    int best_age = 0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        int age = (int'(tags[i]) - int'(head) + RS) % RS;
        if (best < 0 || age < best_age) begin
          best = i;
          best_age = age;
        end
      end
    end
    return best;
  endfunction

  function automatic bit ref_load();
    return !flush && (!m_valid || can_go);
  endfunction

  function automatic logic [3:0] ref_grant();
    int w = ref_winner();
    if (!reset_n || !ref_load() || w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_v1 = '0; m_v2 = '0; m_cmd = '0; m_tag = '0; m_cnt16 = 0; m_cnt4 = 0;
  endtask

  // Advance one rising edge and update the model from the inputs present at that edge.
  task automatic tick();
    int w = ref_winner();
    bit ld = ref_load();
    @(posedge clk);
    if (flush) begin
      m_valid = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_valid = 1; m_v1 = v1[w]; m_v2 = v2[w]; m_cmd = cmd[w]; m_tag = tags[w];
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) begin
      v1[i]  = {$urandom, $urandom};
      v2[i]  = {$urandom, $urandom};
      cmd[i] = 10'($urandom);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; req = 4'hF; can_go = 1; flush = 0; head = '0;
    for (int i = 0; i < 4; i++) tags[i] = TW'(i);
    rand_data();
    model_reset();
    #1;
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (avalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", avalid); end
    total++; if (cnt16 !== 16'd0 || cnt4 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d/%0d exp=0/0", cnt16, cnt4); end
    total++; if ({a1, a2, acmd, atag} !== '0) begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", a1, a2, acmd, atag); end
    req = 4'b0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_basic();
    head = 0; tags[1] = 5; tags[2] = 3; req = 4'b0110; can_go = 1; flush = 0;
    #1;
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL basic_grant got=%b exp=0100", grant); end
    tick();
    total++; if (atag !== 6'd3 || avalid !== 1'b1) begin bad++; $display("FAIL basic_out got tag=%0d v=%b exp tag=3 v=1", atag, avalid); end
    total++; if (cnt16 !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", cnt16); end
    total++; if (a1 !== v1[2] || acmd !== cmd[2]) begin bad++; $display("FAIL basic_data got=%h/%h exp=%h/%h", a1, acmd, v1[2], cmd[2]); end
  endtask

  task automatic test_wrap();
    head = 30; tags[0] = 1; tags[3] = 31; req = 4'b1001; can_go = 1;
    #1;
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL wrap_grant got=%b exp=1000", grant); end
    tick();
    total++; if (atag !== 6'd31) begin bad++; $display("FAIL wrap_tag got=%0d exp=31", atag); end
  endtask

  task automatic test_backpressure();
    logic [63:0] held = v1[3];
    req = 4'b0001; can_go = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (grant !== 4'b0 || stall !== 1'b1) begin bad++; $display("FAIL bp_stall[%0d] got g=%b s=%b exp g=0000 s=1", k, grant, stall); end
      total++; if (atag !== 6'd31 || a1 !== held) begin bad++; $display("FAIL bp_hold[%0d] got tag=%0d a1=%h exp tag=31 a1=%h", k, atag, a1, held); end
      tick();
    end
    can_go = 1;
    #1;
    total++; if (grant !== 4'b0001 || stall !== 1'b0) begin bad++; $display("FAIL bp_release got g=%b s=%b exp g=0001 s=0", grant, stall); end
    tick();
    total++; if (atag !== 6'd1 || cnt16 !== 16'd3) begin bad++; $display("FAIL bp_next got tag=%0d cnt=%0d exp tag=1 cnt=3", atag, cnt16); end
  endtask

  task automatic test_flush();
    flush = 1; can_go = 1; req = 4'b1111;
    #1;
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL flush_grant got=%b exp=0000", grant); end
    tick();
    total++; if (avalid !== 1'b0 || cnt16 !== 16'd3) begin bad++; $display("FAIL flush_state got v=%b cnt=%0d exp v=0 cnt=3", avalid, cnt16); end
    flush = 0; req = 4'b0;
  endtask

  task automatic test_streaming();
    int order [4] = '{1, 3, 0, 2};
    head = 0; tags[0] = 7; tags[1] = 2; tags[2] = 9; tags[3] = 4;
    rand_data(); req = 4'b1111; can_go = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (grant !== 4'(1 << order[k])) begin bad++; $display("FAIL stream_grant[%0d] got=%b exp=%b", k, grant, 4'(1 << order[k])); end
      tick();
      total++; if (atag !== tags[order[k]] || a2 !== v2[order[k]]) begin bad++; $display("FAIL stream_out[%0d] got tag=%0d exp=%0d", k, atag, tags[order[k]]); end
      req[order[k]] = 1'b0;
    end
    tick();
    total++; if (avalid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b exp=0", avalid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      req = 4'($urandom); head = TW'($urandom_range(0, RS - 1));
      for (int i = 0; i < 4; i++) tags[i] = TW'($urandom_range(0, RS - 1));
      rand_data();
      can_go = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 9) == 0);
      #1;
      total++; if (grant !== ref_grant() || d4_grant !== ref_grant()) begin bad++; $display("FAIL rand_grant[%0d] got=%b/%b exp=%b", n, grant, d4_grant, ref_grant()); end
      total++; if (stall !== (m_valid && !can_go) || d4_stall !== (m_valid && !can_go)) begin bad++; $display("FAIL rand_stall[%0d] got=%b exp=%b", n, stall, m_valid && !can_go); end
      tick();
      total++; if (avalid !== m_valid || d4_avalid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d] got=%b exp=%b", n, avalid, m_valid); end
      if (m_valid) begin
        total++;
        if ({a1, a2, acmd, atag} !== {m_v1, m_v2, m_cmd, m_tag} ||
            {d4_a1, d4_a2, d4_acmd, d4_atag} !== {m_v1, m_v2, m_cmd, m_tag}) begin
          bad++; $display("FAIL rand_data[%0d] got tag=%0d cmd=%h exp tag=%0d cmd=%h", n, atag, acmd, m_tag, m_cmd);
        end
      end
      total++; if (cnt16 !== 16'(m_cnt16) || cnt4 !== 4'(m_cnt4)) begin bad++; $display("FAIL rand_count[%0d] got=%0d/%0d exp=%0d/%0d", n, cnt16, cnt4, m_cnt16, m_cnt4); end
    end
    flush = 0;
  endtask

  task automatic test_async_reset();
    req = 4'b0001; can_go = 1; flush = 0; head = 0; tags[0] = 4;
    tick();
    #3;
    reset_n = 0;
    #1;
    total++; if (avalid !== 1'b0 || cnt16 !== 16'd0 || cnt4 !== 4'd0) begin bad++; $display("FAIL async_reset got v=%b cnt=%0d/%0d exp v=0 cnt=0/0", avalid, cnt16, cnt4); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL async_grant got=%b exp=0000", grant); end
    model_reset();
    #2;
    reset_n = 1;
  endtask

  task automatic test_saturation();
    req = 4'b0001; can_go = 1; flush = 0;
    for (int k = 0; k < 20; k++) tick();
    total++; if (cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt4); end
    total++; if (cnt16 !== 16'd20) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=20", cnt16); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_flush();
    test_streaming();
    test_random();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
